// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler: four-floor elevator call scheduler with edge-detected buttons and a directional sweep
// Ports: clk, rst_n (async active-low); call_btn[3:0] level call buttons; present_floor[3:0] one-hot floor feedback;
//        target_floor[3:0] one-hot requested floor; pending[3:0] outstanding requests; dir_up/dir_down travel state;
//        door_open high during dwell. Define ELEVATOR_BTN_SYNC_EN to add a 2-flop button synchronizer (+2 cycles latency).
module elevator_request_scheduler #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] call_btn,
  input  logic [3:0] present_floor,
  output logic [3:0] target_floor,
  output logic [3:0] pending,
  output logic       dir_up,
  output logic       dir_down,
  output logic       door_open
);
  typedef enum logic [1:0] {IDLE, UP, DOWN, DWELL} state_t;
  state_t state, state_nx;
  logic lastdir, lastdir_nx, valid, go_up, go_down, pref_up;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] btn_s, cur, prev, rise, clr, below, above, pa, pb, lo_pa, hi_pb, target_nx, pending_nx;
`ifdef ELEVATOR_BTN_SYNC_EN
  logic [3:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= call_btn;
      sync2 <= sync1;
    end
  assign btn_s = sync2;
`else
  assign btn_s = call_btn;
`endif
  // cur is the sample register, prev the previous sample; a request fires one cycle after sampling
  assign rise  = cur & ~prev;
  assign below = present_floor - 4'd1;
  assign above = ~(below | present_floor);
  assign valid = (present_floor != 4'd0) && ((present_floor & below) == 4'd0);
  assign pa    = pending & above;
  assign pb    = pending & below;
  assign lo_pa = pa & (~pa + 4'd1);
  assign hi_pb = pb[3] ? 4'b1000 : pb[2] ? 4'b0100 : pb[1] ? 4'b0010 : pb[0] ? 4'b0001 : 4'b0000;
  // while travelling only the committed target floor is cleared on pass-through
  assign clr = valid ? present_floor & (((state == UP) || (state == DOWN)) ? target_floor : 4'hf) : 4'h0;
  assign pending_nx = (pending | rise) & ~clr;
  // IDLE prefers up; DWELL prefers the direction of the last travel
  assign pref_up = (state == IDLE) ? 1'b1 : lastdir;
  assign go_up   = (pa != 4'd0) && (pref_up || (pb == 4'd0));
  assign go_down = (pb != 4'd0) && !go_up;
  always_comb begin
    state_nx   = state;
    target_nx  = present_floor;
    lastdir_nx = lastdir;
    cnt_nx     = cnt;
    if (!valid) begin
      state_nx  = IDLE;
      target_nx = 4'b0001;
    end else begin
      case (state)
        UP, DOWN: begin
          if (present_floor == target_floor) begin
            state_nx   = DWELL;
            cnt_nx     = 8'(DWELL_CYCLES - 1);
            lastdir_nx = (state == UP);
          end else if ((state == UP) ? (pa != 4'd0) : (pb != 4'd0)) begin
            target_nx = (state == UP) ? lo_pa : hi_pb;
          end else begin
            state_nx = IDLE;
          end
        end
        DWELL: begin
          if (cnt != 8'd0) begin
            cnt_nx = cnt - 8'd1;
          end else begin
            state_nx  = go_up ? UP : go_down ? DOWN : IDLE;
            target_nx = go_up ? lo_pa : go_down ? hi_pb : present_floor;
          end
        end
        default: begin
          state_nx  = go_up ? UP : go_down ? DOWN : IDLE;
          target_nx = go_up ? lo_pa : go_down ? hi_pb : present_floor;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      lastdir      <= 1'b1;
      cnt          <= '0;
      cur          <= '0;
      prev         <= '0;
      pending      <= '0;
      target_floor <= 4'b0001;
      dir_up       <= 1'b0;
      dir_down     <= 1'b0;
      door_open    <= 1'b0;
    end else begin
      state        <= state_nx;
      lastdir      <= lastdir_nx;
      cnt          <= cnt_nx;
      cur          <= btn_s;
      prev         <= cur;
      pending      <= pending_nx;
      target_floor <= target_nx;
      dir_up       <= (state_nx == UP);
      dir_down     <= (state_nx == DOWN);
      door_open    <= (state_nx == DWELL);
    end
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb_elevator_request_scheduler: directed table-driven bench for elevator_request_scheduler
module tb_elevator_request_scheduler;
`ifdef ELEVATOR_BTN_SYNC_EN
  localparam int XL = 2;
`else
  localparam int XL = 0;
`endif
  logic clk = 1'b0, rst_n;
  logic [3:0] call_btn, present_floor, target_floor, pending;
  logic dir_up, dir_down, door_open;
  logic [10:0] obs;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [3:0] btn, pf, t, p;
    logic up, dn, door;
  } vec_t;
  vec_t vecs[$];
  elevator_request_scheduler #(.DWELL_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .call_btn(call_btn), .present_floor(present_floor),
    .target_floor(target_floor), .pending(pending), .dir_up(dir_up), .dir_down(dir_down), .door_open(door_open)
  );
  always #5 clk = ~clk;
  assign obs = {target_floor, pending, dir_up, dir_down, door_open};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got t=%b p=%b up/dn/door=%b, expected t=%b p=%b up/dn/door=%b",
               name, act[10:7], act[6:3], act[2:0], exp[10:7], exp[6:3], exp[2:0]);
    end
  endtask
  task automatic add(input logic [3:0] btn, pf, t, p, input logic up, dn, door);
    vec_t v;
    v.btn = btn; v.pf = pf; v.t = t; v.p = p; v.up = up; v.dn = dn; v.door = door;
    vecs.push_back(v);
  endtask
  task automatic add_n(input int n, input logic [3:0] btn, pf, t, p, input logic up, dn, door);
    for (int i = 0; i < n; i++) add(btn, pf, t, p, up, dn, door);
  endtask
  initial begin
    // press 0100 at floor 0: pending after one edge, UP after two, dwell 4 cycles
    add(4'h4, 4'h1, 4'h1, 4'h0, 0, 0, 0);
    add(4'h0, 4'h1, 4'h1, 4'h4, 0, 0, 0);
    add(4'h0, 4'h1, 4'h4, 4'h4, 1, 0, 0);
    add_n(4, 4'h0, 4'h4, 4'h4, 4'h0, 0, 0, 1);
    add(4'h0, 4'h4, 4'h4, 4'h0, 0, 0, 0);
    // call at the current floor never shows as pending; zero floor forces target 0001
    add(4'h4, 4'h4, 4'h4, 4'h0, 0, 0, 0);
    add(4'h0, 4'h4, 4'h4, 4'h0, 0, 0, 0);
    add(4'h0, 4'h0, 4'h1, 4'h0, 0, 0, 0);
    add(4'h0, 4'h1, 4'h1, 4'h0, 0, 0, 0);
    // 1000 then 0010 while going up: retarget to the nearer floor
    add(4'h8, 4'h1, 4'h1, 4'h0, 0, 0, 0);
    add(4'h0, 4'h1, 4'h1, 4'h8, 0, 0, 0);
    add(4'h2, 4'h1, 4'h8, 4'h8, 1, 0, 0);
    add(4'h0, 4'h1, 4'h8, 4'ha, 1, 0, 0);
    add(4'h0, 4'h1, 4'h2, 4'ha, 1, 0, 0);
    add_n(4, 4'h0, 4'h2, 4'h2, 4'h8, 0, 0, 1);
    add(4'h0, 4'h2, 4'h8, 4'h8, 1, 0, 0);
    add(4'h0, 4'h4, 4'h8, 4'h8, 1, 0, 0);
    add_n(4, 4'h0, 4'h8, 4'h8, 4'h0, 0, 0, 1);
    add(4'h0, 4'h8, 4'h8, 4'h0, 0, 0, 0);
    // at floor 2 with {0001,1000}: up first, then down to ground
    add(4'h9, 4'h4, 4'h4, 4'h0, 0, 0, 0);
    add(4'h0, 4'h4, 4'h4, 4'h9, 0, 0, 0);
    add(4'h0, 4'h4, 4'h8, 4'h9, 1, 0, 0);
    add_n(4, 4'h0, 4'h8, 4'h8, 4'h1, 0, 0, 1);
    add(4'h0, 4'h8, 4'h1, 4'h1, 0, 1, 0);
    add(4'h0, 4'h2, 4'h1, 4'h1, 0, 1, 0);
    add_n(4, 4'h0, 4'h1, 4'h1, 4'h0, 0, 0, 1);
    add(4'h0, 4'h1, 4'h1, 4'h0, 0, 0, 0);
    // multi-hot floor: IDLE with target 0001, requests still accumulate
    add(4'h8, 4'h3, 4'h1, 4'h0, 0, 0, 0);
    add(4'h0, 4'h3, 4'h1, 4'h8, 0, 0, 0);
    add(4'h0, 4'h3, 4'h1, 4'h8, 0, 0, 0);
    add(4'h0, 4'h1, 4'h8, 4'h8, 1, 0, 0);
    add_n(4, 4'h0, 4'h8, 4'h8, 4'h0, 0, 0, 1);
    add(4'h0, 4'h8, 4'h8, 4'h0, 0, 0, 0);
    add(4'h0, 4'h1, 4'h1, 4'h0, 0, 0, 0);

    rst_n = 1'b0; call_btn = 4'h0; present_floor = 4'h1;
    steps(3);
    chk("reset", obs, {4'h1, 4'h0, 3'b000});
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      call_btn = vecs[i].btn;
      present_floor = vecs[i].pf;
      step();
      chk($sformatf("row%0d", i), obs, {vecs[i].t, vecs[i].p, vecs[i].up, vecs[i].dn, vecs[i].door});
      if (vecs[i].btn != 4'h0) begin
        call_btn = 4'h0;
        steps(XL);
      end
    end
    // held button yields exactly one request
    call_btn = 4'h2;
    steps(3 + XL);
    chk("hold_travel", obs, {4'h2, 4'h2, 3'b100});
    present_floor = 4'h2;
    step();
    chk("hold_arrive", obs, {4'h2, 4'h0, 3'b001});
    for (int i = 0; i < 46; i++) begin
      step();
      chk($sformatf("hold_pend%0d", i), {7'h0, pending}, 11'h0);
    end
    chk("hold_idle", obs, {4'h2, 4'h0, 3'b000});
    call_btn = 4'h0;
    step();
    // reach DWELL at floor 2 with 1001 pending, then reset asynchronously
    call_btn = 4'hd;
    step();
    call_btn = 4'h0;
    steps(1 + XL);
    chk("rst_setup_pend", obs, {4'h2, 4'hd, 3'b000});
    step();
    chk("rst_setup_up", obs, {4'h4, 4'hd, 3'b100});
    present_floor = 4'h4;
    step();
    chk("rst_setup_dwell", obs, {4'h4, 4'h9, 3'b001});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", obs, {4'h1, 4'h0, 3'b000});
    steps(2);
    chk("reset_held", obs, {4'h1, 4'h0, 3'b000});
    present_floor = 4'h1;
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", obs, {4'h1, 4'h0, 3'b000});
    call_btn = 4'h4;
    step();
    call_btn = 4'h0;
    steps(1 + XL);
    chk("lat_pending", obs, {4'h1, 4'h4, 3'b000});
    step();
    chk("lat_target", obs, {4'h4, 4'h4, 3'b100});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
